// File: rtl/branch_flush_ctrl.sv
// Branch resolution and pipeline flush controller. It detects mispredicts in EX,
// issues a redirect to the PC unit, squashes IF/ID and ID/EX, and keeps branch statistics.
module branch_flush_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             ex_branch,
   input  logic             ex_jump,
   input  logic             ex_taken,
   input  logic             ex_pred_taken,
   input  logic [31:0]      ex_target,
   input  logic [31:0]      ex_pc_plus4,
   input  logic             stall,
   input  logic             redirect_ready,
   input  logic             cnt_clr,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             busy,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REDIRECT = 2'd1;
   localparam logic [1:0] FLUSH    = 2'd2;

   localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   logic [1:0] state;
   logic [1:0] state_n;
   logic [2:0] flush_cnt;
   logic [2:0] flush_cnt_n;
   logic       ev;
   logic       act;
   logic       mp;
   logic       idle_ev;
   logic       idle_mp;

   assign ev      = ex_valid & ~stall & (ex_branch | ex_jump);
   assign act     = ex_jump | ex_taken;
   assign mp      = ev & (act != ex_pred_taken);
   // Events seen outside IDLE belong to the squashed wrong path.
   assign idle_ev = (state == IDLE) & ev;
   assign idle_mp = (state == IDLE) & mp;

   always_comb begin
      state_n     = state;
      flush_cnt_n = flush_cnt;
      case (state)
         IDLE: begin
            if (mp) begin
               state_n = REDIRECT;
            end
         end
         REDIRECT: begin
            if (redirect_valid && redirect_ready) begin
               state_n     = FLUSH;
               flush_cnt_n = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (!stall) begin
               if (flush_cnt == 3'd0) begin
                  state_n = IDLE;
               end else begin
                  flush_cnt_n = flush_cnt - 3'd1;
               end
            end
         end
         default: begin
            state_n     = IDLE;
            flush_cnt_n = 3'd0;
         end
      endcase
   end

   // Outputs are registered from the next state so nothing passes straight from inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         flush_cnt      <= 3'd0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'h0;
         flush_if_id    <= 1'b0;
         flush_id_ex    <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state          <= state_n;
         flush_cnt      <= flush_cnt_n;
         redirect_valid <= (state_n == REDIRECT);
         flush_if_id    <= (state_n != IDLE);
         flush_id_ex    <= (state_n != IDLE);
         busy           <= (state_n != IDLE);
         if (idle_mp) begin
            redirect_pc <= act ? ex_target : ex_pc_plus4;
         end
      end
   end

   // Saturating statistics; a clear request always beats a same-cycle increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (cnt_clr) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (idle_ev && branch_cnt != CNT_MAX) begin
            branch_cnt <= branch_cnt + CNT_ONE;
         end
         if (idle_mp && mispred_cnt != CNT_MAX) begin
            mispred_cnt <= mispred_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed scoreboard bench for branch_flush_ctrl (FLUSH_CYCLES=2, 4-bit counters
// so saturation is reachable quickly).
module tb_branch_flush_ctrl;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_branch;
   logic        ex_jump;
   logic        ex_taken;
   logic        ex_pred_taken;
   logic [31:0] ex_target;
   logic [31:0] ex_pc_plus4;
   logic        stall;
   logic        redirect_ready;
   logic        cnt_clr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        busy;
   logic [3:0]  branch_cnt;
   logic [3:0]  mispred_cnt;

   typedef struct {
      string       tag;
      logic        rv;
      logic [31:0] pc;
      logic        pc_chk;
      logic        fl;
      logic        bsy;
      logic [3:0]  bc;
      logic [3:0]  mc;
   } exp_t;

   exp_t       sb[$];
   int         n_vec = 0;
   int         n_mis = 0;
   logic [3:0] exp_bc = 4'd0;
   logic [3:0] exp_mc = 4'd0;

   branch_flush_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_branch      (ex_branch),
      .ex_jump        (ex_jump),
      .ex_taken       (ex_taken),
      .ex_pred_taken  (ex_pred_taken),
      .ex_target      (ex_target),
      .ex_pc_plus4    (ex_pc_plus4),
      .stall          (stall),
      .redirect_ready (redirect_ready),
      .cnt_clr        (cnt_clr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .busy           (busy),
      .branch_cnt     (branch_cnt),
      .mispred_cnt    (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   task automatic applyStimulus(input logic v, input logic br, input logic jmp, input logic tk,
                                input logic pred, input logic [31:0] tgt, input logic [31:0] pc4,
                                input logic stl, input logic rdy, input logic clr);
      ex_valid       = v;
      ex_branch      = br;
      ex_jump        = jmp;
      ex_taken       = tk;
      ex_pred_taken  = pred;
      ex_target      = tgt;
      ex_pc_plus4    = pc4;
      stall          = stl;
      redirect_ready = rdy;
      cnt_clr        = clr;
   endtask

   task automatic pushExpect(input string tag, input logic rv, input logic [31:0] pc,
                             input logic pc_chk, input logic fl, input logic bsy);
      exp_t e;
      e.tag    = tag;
      e.rv     = rv;
      e.pc     = pc;
      e.pc_chk = pc_chk;
      e.fl     = fl;
      e.bsy    = bsy;
      e.bc     = exp_bc;
      e.mc     = exp_mc;
      sb.push_back(e);
   endtask

   // Observed word: {redirect_valid, redirect_pc, flush_if_id, flush_id_ex, busy, branch_cnt, mispred_cnt}
   task automatic checkOutput();
      exp_t        e;
      logic [43:0] obs;
      logic [43:0] expv;
      if (sb.size() == 0) begin
         n_vec++;
         n_mis++;
         $error("[TB] FAIL scoreboard_empty: observed no expectation, expected one queued");
      end else begin
         e    = sb.pop_front();
         n_vec++;
         obs  = {redirect_valid, (e.pc_chk ? redirect_pc : 32'h0), flush_if_id, flush_id_ex,
                 busy, branch_cnt, mispred_cnt};
         expv = {e.rv, (e.pc_chk ? e.pc : 32'h0), e.fl, e.fl, e.bsy, e.bc, e.mc};
         assert (obs === expv) else begin
            n_mis++;
            $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, expv);
         end
      end
   endtask

   task automatic step(input string tag, input logic rv, input logic [31:0] pc,
                       input logic pc_chk, input logic fl, input logic bsy);
      pushExpect(tag, rv, pc, pc_chk, fl, bsy);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
      #1;
      pushExpect("reset", 0, 32'h0, 1, 0, 0);
      checkOutput();
      @(negedge clk);
      rst = 1'b1;

      // Not-taken prediction, branch taken: redirect to target, 3 flush cycles
      applyStimulus(1, 1, 0, 1, 0, 32'h0000_0100, 32'h0000_0008, 0, 1, 0);
      exp_bc = sat_inc(exp_bc);
      exp_mc = sat_inc(exp_mc);
      step("beq_redirect", 1, 32'h100, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
      step("beq_flush1", 0, 32'h0, 0, 1, 1);
      step("beq_flush2", 0, 32'h0, 0, 1, 1);
      step("beq_idle", 0, 32'h0, 0, 0, 0);

      // Taken prediction, falls through, PC unit back-pressures for 4 cycles
      applyStimulus(1, 1, 0, 0, 1, 32'h0000_0200, 32'h0000_0024, 0, 0, 0);
      exp_bc = sat_inc(exp_bc);
      exp_mc = sat_inc(exp_mc);
      step("nt_redirect0", 1, 32'h24, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
      step("nt_redirect1", 1, 32'h24, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
      step("nt_redirect2_stall", 1, 32'h24, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
      step("nt_redirect3", 1, 32'h24, 1, 1, 1);
      step("nt_redirect4", 1, 32'h24, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
      step("nt_flush1", 0, 32'h0, 0, 1, 1);
      step("nt_flush2", 0, 32'h0, 0, 1, 1);
      step("nt_idle", 0, 32'h0, 0, 0, 0);

      // Correctly predicted jump, invalid branch, stalled mispredict
      applyStimulus(1, 0, 1, 0, 1, 32'h0000_0040, 32'h0000_0010, 0, 1, 0);
      exp_bc = sat_inc(exp_bc);
      step("jump_correct", 0, 32'h0, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 32'h0000_0040, 32'h0000_0010, 0, 1, 0);
      step("invalid_branch", 0, 32'h0, 0, 0, 0);
      applyStimulus(1, 1, 0, 1, 0, 32'h0000_0040, 32'h0000_0010, 1, 1, 0);
      step("stalled_branch", 0, 32'h0, 0, 0, 0);

      // Wrong-path mispredict held during FLUSH, FLUSH stretched by 2 stall cycles
      applyStimulus(1, 1, 0, 1, 0, 32'h0000_0300, 32'h0000_0030, 0, 1, 0);
      exp_bc = sat_inc(exp_bc);
      exp_mc = sat_inc(exp_mc);
      step("wp_redirect", 1, 32'h300, 1, 1, 1);
      applyStimulus(1, 1, 0, 1, 0, 32'h0000_0999, 32'h0000_0030, 0, 1, 0);
      step("wp_flush_a", 0, 32'h0, 0, 1, 1);
      applyStimulus(1, 1, 0, 1, 0, 32'h0000_0999, 32'h0000_0030, 1, 1, 0);
      step("wp_flush_stall1", 0, 32'h0, 0, 1, 1);
      step("wp_flush_stall2", 0, 32'h0, 0, 1, 1);
      applyStimulus(1, 1, 0, 1, 0, 32'h0000_0999, 32'h0000_0030, 0, 1, 0);
      step("wp_flush_b", 0, 32'h0, 0, 1, 1);
      step("wp_idle", 0, 32'h0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
      step("wp_idle_quiet", 0, 32'h0, 0, 0, 0);

      // Drive both counters into saturation
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1, 1, 0, 1, 0, 32'h0000_0500, 32'h0000_0050, 0, 1, 0);
         exp_bc = sat_inc(exp_bc);
         exp_mc = sat_inc(exp_mc);
         step("sat_redirect", 1, 32'h500, 1, 1, 1);
         applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
         step("sat_flush1", 0, 32'h0, 0, 1, 1);
         step("sat_flush2", 0, 32'h0, 0, 1, 1);
         step("sat_idle", 0, 32'h0, 0, 0, 0);
      end

      // Clear beats a coincident increment and leaves the FSM alone
      applyStimulus(1, 1, 0, 1, 0, 32'h0000_0400, 32'h0000_0040, 0, 0, 1);
      exp_bc = 4'd0;
      exp_mc = 4'd0;
      step("clr_with_mp", 1, 32'h400, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
      step("clr_redirect_hold", 1, 32'h400, 1, 1, 1);

      // Asynchronous reset in the middle of REDIRECT
      #2;
      rst = 1'b0;
      #1;
      pushExpect("async_reset", 0, 32'h0, 1, 0, 0);
      checkOutput();
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step("post_reset_idle", 0, 32'h0, 0, 0, 0);
      step("post_reset_quiet", 0, 32'h0, 0, 0, 0);
      applyStimulus(1, 0, 1, 0, 1, 32'h0000_0080, 32'h0000_0020, 0, 1, 0);
      exp_bc = sat_inc(exp_bc);
      step("post_reset_jump", 0, 32'h0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
      step("final_idle", 0, 32'h0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
